cordic_step_sequencer: RTL
==========================

Name: cordic_step_sequencer

Overview:
- Iteration controller for the CORDIC direction-decision logic and its shift-add datapath.
- Walks the datapath through NSTEPS micro-rotations and drives the one-hot stage select and valid into the decision logic.
- Consumes the decision pair d/dn and issues load/update strobes with a latched rotation direction.
- Provides a start/busy/done handshake to the host, plus error reporting for conflicting or missing decisions.

Parameters:
NSTEPS, 5, number of micro-rotation stages; width of step_o (one stage-select bit per stage)
TIMEOUT, 3, max consecutive EVAL cycles with d_i=dn_i=0 before error; range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start_i  input  1  host request to begin a rotation sequence
abort_i  input  1  host request to cancel the current sequence
d_i  input  1  decision unit: rotate in positive direction
dn_i  input  1  decision unit: rotate in negative direction / no-rotate
step_o  output  NSTEPS  one-hot stage select to decision unit and datapath
v_o  output  1  valid to decision unit; decision requested this cycle
ld_o  output  1  load operands into datapath (1-cycle pulse)
upd_o  output  1  apply one micro-rotation using dir_o (1-cycle pulse)
dir_o  output  1  latched direction: 1 = d, 0 = dn
iter_o  output  clog2(NSTEPS+1)  current stage index
busy_o  output  1  sequence in progress
done_o  output  1  sequence complete (1-cycle pulse)
err_o  output  1  sequence failed (sticky)

Behaviour:
- Reset: rst high asynchronously forces IDLE. All outputs are 0, iter and stall counter are 0, and err is cleared. This applies mid-sequence too; no done pulse is emitted.
- Output timing: every output is a function of registered state only; no combinational path from any input to any output.
- States: IDLE, LOAD, EVAL, UPDATE, DONE, ERR.
- IDLE:
  - start_i=1 and abort_i=0 -> LOAD.
  - start_i=1 and abort_i=1 together -> stay in IDLE (abort wins).
- LOAD:
  - ld_o=1, busy_o=1.
  - Clear iter to 0 and the stall counter to 0.
  - Next state: EVAL.
- EVAL:
  - Outputs: v_o=1, busy_o=1, step_o = 1<<iter.
  - d_i=1, dn_i=0 -> dir=1, go to UPDATE.
  - d_i=0, dn_i=1 -> dir=0, go to UPDATE.
  - d_i=1, dn_i=1 -> conflict, go to ERR.
  - d_i=0, dn_i=0 -> stall: increment stall counter and stay in EVAL. When the counter reaches TIMEOUT, go to ERR instead.
  - Stall counter clears on every transition into EVAL.
- UPDATE:
  - Outputs: upd_o=1, busy_o=1, step_o = 1<<iter.
  - dir_o holds the value captured in EVAL.
  - iter==NSTEPS-1 -> DONE; otherwise iter+1 and go to EVAL.
- DONE:
  - done_o=1 for exactly one cycle, busy_o=0, then IDLE.
  - iter_o holds NSTEPS-1.
- ERR:
  - err_o=1 (sticky), busy_o=0.
  - start_i=1 -> LOAD, and err clears on entry to LOAD.
  - abort_i=1 -> IDLE, and err clears.
- dir_o: changes only on leaving EVAL toward UPDATE; otherwise holds, including through DONE/IDLE.
- step_o: 0 outside EVAL/UPDATE.
- Abort: abort_i=1 in LOAD, EVAL or UPDATE -> IDLE on the next edge. No upd_o or done_o pulse is generated after that edge.
- start_i while busy is ignored.
- Latency with no stalls, start sampled at edge 0:
  - ld_o high in cycle 1.
  - Stage k EVAL at cycle 2+2k, UPDATE at cycle 3+2k.
  - done_o at cycle 2+2*NSTEPS (cycle 12 for NSTEPS=5).
  - Each stall adds one cycle.
- Back-to-back: start_i high in the DONE cycle is ignored. A new start is accepted in the IDLE cycle that follows.

Test Plan:
- Reset, then start_i pulse with d_i=1, dn_i=0 constant:
  - ld_o at cycle 1.
  - step_o = 00001, 00010, 00100, 01000, 10000 across EVAL/UPDATE pairs.
  - Five upd_o pulses, dir_o=1, done_o at cycle 12, busy_o low at cycle 12.
- Alternating decisions dn, d, dn, d, dn per EVAL: dir_o during the five UPDATE cycles = 0,1,0,1,0; done_o at cycle 12.
- d_i=dn_i=0 for 2 cycles in stage 2, then d_i=1: no error, done_o at cycle 14. Hold both 0 for 3 cycles instead: err_o=1, busy_o=0, no upd_o for stage 2.
- d_i=dn_i=1 at stage 0 EVAL: ERR next cycle, err_o stays 1. A start_i then reaches LOAD with err_o=0, and the run completes normally.
- abort_i at stage 3 UPDATE+1 (EVAL): IDLE next edge, no done_o. start_i with abort_i simultaneously in IDLE: no ld_o.
- rst asserted asynchronously mid-EVAL: outputs immediately 0, iter_o=0. After release, start_i yields a full sequence.

Source files
------------

// File: rtl/cordic_step_sequencer.sv
// Iteration controller for a CORDIC shift-add datapath: walks NSTEPS micro-rotations,
// requests a direction decision per stage and strobes load/update with the latched direction.
module cordic_step_sequencer #(
    parameter int NSTEPS  = 5,
    parameter int TIMEOUT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            d_i,
    input  logic                            dn_i,
    output logic [NSTEPS-1:0]               step_o,
    output logic                            v_o,
    output logic                            ld_o,
    output logic                            upd_o,
    output logic                            dir_o,
    output logic [$clog2(NSTEPS+1)-1:0]     iter_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | load operands into datapath
    // EVAL   | decision requested for stage iter
    // UPDATE | apply micro-rotation for stage iter using dir
    // DONE   | one-cycle completion pulse
    // ERR    | conflicting or missing decision; held until start/abort

    localparam int IW = $clog2(NSTEPS + 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(NSTEPS - 1);
    localparam logic [3:0]    STALL_MAX = 4'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EVAL   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   iter, iter_n;
    logic [3:0]      stall, stall_n;
    logic            dir, dir_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            iter  <= '0;
            stall <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            iter  <= iter_n;
            stall <= stall_n;
            dir   <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        iter_n  = iter;
        stall_n = stall;
        dir_n   = dir;
        case (state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_n = S_LOAD;
                    iter_n  = '0;
                    stall_n = '0;
                end
            end
            S_LOAD: begin
                iter_n  = '0;
                stall_n = '0;
                state_n = abort_i ? S_IDLE : S_EVAL;
            end
            S_EVAL: begin
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (d_i && dn_i) begin
                    state_n = S_ERR;
                end else if (d_i || dn_i) begin
                    dir_n   = d_i;
                    state_n = S_UPDATE;
                end else if (stall == STALL_MAX) begin
                    state_n = S_ERR;
                end else begin
                    stall_n = stall + 4'd1;
                end
            end
            S_UPDATE: begin
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (iter == LAST_ITER) begin
                    state_n = S_DONE;
                end else begin
                    iter_n  = iter + IW'(1);
                    stall_n = '0;
                    state_n = S_EVAL;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERR: begin
                // abort takes precedence over a simultaneous restart
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (start_i) begin
                    state_n = S_LOAD;
                    iter_n  = '0;
                    stall_n = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        step_o = '0;
        if (state == S_EVAL || state == S_UPDATE) begin
            for (int i = 0; i < NSTEPS; i++) begin
                step_o[i] = (iter == IW'(i));
            end
        end
        v_o    = (state == S_EVAL);
        ld_o   = (state == S_LOAD);
        upd_o  = (state == S_UPDATE);
        busy_o = (state == S_LOAD) || (state == S_EVAL) || (state == S_UPDATE);
        done_o = (state == S_DONE);
        err_o  = (state == S_ERR);
        dir_o  = dir;
        iter_o = iter;
    end

endmodule
